// File: rtl/nand_flash_responder_if.sv
// NAND flash bus between a controller (master) and a flash device (slave).
// Latency: none, wires only. Backpressure: device busy is signalled on f_rb_o (0 = busy).
// Ports: f_io_i cmd/addr/data to the device; f_io_o/f_oe_o device read data and its drive
//        enable (pad tristate F_IO = f_oe_o ? f_io_o : 'z lives at the pad ring);
//        f_cle_i/f_ale_i latch enables; f_wen_i/f_ren_i strobes; f_rb_o ready/busy.
interface nand_flash_responder_if;
  logic [7:0] f_io_i;
  logic [7:0] f_io_o;
  logic       f_oe_o;
  logic       f_cle_i;
  logic       f_ale_i;
  logic       f_wen_i;
  logic       f_ren_i;
  logic       f_rb_o;

  modport master (
    output f_io_i, f_cle_i, f_ale_i, f_wen_i, f_ren_i,
    input  f_io_o, f_oe_o, f_rb_o
  );

  modport slave (
    input  f_io_i, f_cle_i, f_ale_i, f_wen_i, f_ren_i,
    output f_io_o, f_oe_o, f_rb_o
  );
endinterface

// File: rtl/nand_flash_responder.sv
// NAND flash device model: decodes 00h/01h/80h/10h/70h/FFh, 3-cycle addressing, page array.
// Latency: read data ready one cycle after each sampled REN rise; F_RB low exactly T_* cycles.
// Backpressure: F_RB=0 while busy; only FFh and 70h are decoded in that window.
// Ports: clk, rst (sync, active high); nf = slave side of nand_flash_responder_if.
// Addressing packs {ptr_half, byte} into the column and {byte0 bit0, byte} into the row,
// so COL_W and ROW_W are expected to be 9.
module nand_flash_responder #(
  parameter int COL_W  = 9,
  parameter int ROW_W  = 9,
  parameter int T_R    = 20,
  parameter int T_PROG = 50,
  parameter int T_RST  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  nand_flash_responder_if.slave nf
);

  localparam int AW    = COL_W + ROW_W;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_R_BUSY, S_R_DATA, S_P_DATA, S_P_BUSY, S_RST_BUSY
  } state_t;

  logic [7:0]       mem_q [DEPTH];
  state_t           state_q;
  logic             wen_q, ren_q, rb_q;
  logic             ptr_half_q, status_q, addr_prog_q;
  logic [1:0]       addr_cnt_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [15:0]      busy_cnt_q;
  logic [7:0]       dout_q;

  logic             wen_rise, ren_rise, is_cmd, is_addr, is_data, busy, mem_we;
  logic [COL_W-1:0] col_inc_d;

  assign wen_rise  = nf.f_wen_i & ~wen_q;
  assign ren_rise  = nf.f_ren_i & ~ren_q;
  assign is_cmd    = wen_rise &  nf.f_cle_i & ~nf.f_ale_i;
  assign is_addr   = wen_rise & ~nf.f_cle_i &  nf.f_ale_i;
  assign is_data   = wen_rise & ~nf.f_cle_i & ~nf.f_ale_i;
  assign busy      = (state_q == S_R_BUSY) | (state_q == S_P_BUSY) | (state_q == S_RST_BUSY);
  assign col_inc_d = col_q + 1'b1;  // natural wrap within the page
  assign mem_we    = ~rst & is_data & (state_q == S_P_DATA);

  // Array has no reset: contents survive rst, only pending program data is lost.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[{row_q, col_q}] <= nf.f_io_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wen_q       <= 1'b1;
      ren_q       <= 1'b1;
      rb_q        <= 1'b1;
      ptr_half_q  <= 1'b0;
      status_q    <= 1'b0;
      addr_prog_q <= 1'b0;
      addr_cnt_q  <= 2'd0;
      col_q       <= '0;
      row_q       <= '0;
      busy_cnt_q  <= 16'd0;
      dout_q      <= 8'h00;
    end else begin
      wen_q <= nf.f_wen_i;
      ren_q <= nf.f_ren_i;

      // Busy countdown: F_RB dropped on the trigger edge, released T edges later.
      if (busy) begin
        if (busy_cnt_q == 16'd0) begin
          rb_q <= 1'b1;
          case (state_q)
            S_R_BUSY: begin
              state_q <= S_R_DATA;
              dout_q  <= mem_q[{row_q, col_q}];
            end
            S_RST_BUSY: begin
              state_q    <= S_IDLE;
              ptr_half_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
          endcase
        end else begin
          busy_cnt_q <= busy_cnt_q - 16'd1;
        end
      end

      // Command decode comes after the countdown so FFh wins over a same-edge busy exit.
      if (is_cmd) begin
        if (nf.f_io_i == 8'hFF) begin
          state_q    <= S_RST_BUSY;
          rb_q       <= 1'b0;
          busy_cnt_q <= 16'(T_RST - 1);
          status_q   <= 1'b0;
        end else if (nf.f_io_i == 8'h70) begin
          status_q <= 1'b1;
        end else if (!busy) begin
          status_q <= 1'b0;
          case (nf.f_io_i)
            8'h00, 8'h01: begin
              ptr_half_q  <= nf.f_io_i[0];
              state_q     <= S_ADDR;
              addr_cnt_q  <= 2'd0;
              addr_prog_q <= 1'b0;
            end
            8'h80: begin
              state_q     <= S_ADDR;
              addr_cnt_q  <= 2'd0;
              addr_prog_q <= 1'b1;
            end
            8'h10: begin
              if (state_q == S_P_DATA) begin
                state_q    <= S_P_BUSY;
                rb_q       <= 1'b0;
                busy_cnt_q <= 16'(T_PROG - 1);
              end else begin
                state_q <= S_IDLE;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end

      if (is_addr && state_q == S_ADDR) begin
        case (addr_cnt_q)
          2'd0:    col_q      <= COL_W'({ptr_half_q, nf.f_io_i});
          2'd1:    row_q[7:0] <= nf.f_io_i;
          default: begin
            row_q[8] <= nf.f_io_i[0];
            if (addr_prog_q) begin
              state_q <= S_P_DATA;
            end else begin
              state_q    <= S_R_BUSY;
              rb_q       <= 1'b0;
              busy_cnt_q <= 16'(T_R - 1);
            end
          end
        endcase
        addr_cnt_q <= addr_cnt_q + 2'd1;
      end

      if (is_data && state_q == S_P_DATA) col_q <= col_inc_d;

      // Prefetch the next byte on the REN rise so it is stable by the next REN fall.
      if (ren_rise && state_q == S_R_DATA) begin
        col_q  <= col_inc_d;
        dout_q <= mem_q[{row_q, col_inc_d}];
      end
    end
  end

  // Never drive while the controller holds WEN low.
  assign nf.f_oe_o = (status_q | (state_q == S_R_DATA)) & ~nf.f_ren_i & nf.f_wen_i;
  assign nf.f_io_o = status_q ? {1'b1, rb_q, 6'b0} : dout_q;
  assign nf.f_rb_o = rb_q;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed-sequence bench with random page data, checked against a byte-addressed
// reference memory and a transaction-level model of pointer/column state.
module tb_nand_flash_responder;
  localparam int PB = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nand_flash_responder_if nf();

  nand_flash_responder #(.COL_W(9), .ROW_W(9), .T_R(20), .T_PROG(50), .T_RST(5)) dut (
    .clk(clk), .rst(rst), .nf(nf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  byte unsigned mem_m [int];
  int m_half, m_row, m_col;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising clock edge.
  task automatic bus_cycle(input logic cle, input logic ale, input logic [7:0] d);
    nf.f_cle_i = cle; nf.f_ale_i = ale; nf.f_io_i = d; nf.f_wen_i = 1'b0;
    @(posedge clk); #1 nf.f_wen_i = 1'b1;
    @(posedge clk); #1;
    nf.f_cle_i = 1'b0; nf.f_ale_i = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c);
    bus_cycle(1'b1, 1'b0, c);
  endtask

  task automatic addr(input logic [7:0] a);
    bus_cycle(1'b0, 1'b1, a);
  endtask

  task automatic ren_pulse(output logic oe, output logic [7:0] d);
    nf.f_ren_i = 1'b0;
    @(negedge clk); oe = nf.f_oe_o; d = nf.f_io_o;
    @(posedge clk); #1 nf.f_ren_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (nf.f_rb_o) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (nf.f_rb_o) break;
    end
    chk(tag, 32'(nf.f_rb_o), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_addr3(input int row, input logic [7:0] c8);
    logic [7:0] hi;
    hi = 8'($urandom);
    addr(c8);
    addr(8'(row));
    addr({hi[7:1], 1'(row >> 8)});  // upper bits of the third cycle must not matter
  endtask

  task automatic send_read(input int half, input int row, input logic [7:0] c8);
    cmd(half != 0 ? 8'h01 : 8'h00);
    m_half = half;
    send_addr3(row, c8);
    m_row = row;
    m_col = m_half * 256 + int'(c8);
  endtask

  task automatic send_prog(input int row, input logic [7:0] c8);
    cmd(8'h80);
    send_addr3(row, c8);
    m_row = row;
    m_col = m_half * 256 + int'(c8);
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus_cycle(1'b0, 1'b0, d);
    mem_m[m_row * PB + m_col] = d;
    m_col = (m_col + 1) % PB;
  endtask

  task automatic read_check(input int n, input string tag);
    logic oe;
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      ren_pulse(oe, d);
      chk($sformatf("%s[%0d]", tag, k), {23'd0, oe, d}, {23'd0, 1'b1, mem_m[m_row * PB + m_col]});
      m_col = (m_col + 1) % PB;
    end
  endtask

  task automatic fill_page(input int row);
    send_prog(row, 8'h00);
    for (int i = 0; i < PB; i++) write_byte(8'($urandom));
    cmd(8'h10);
    wait_ready($sformatf("fill%0d_ready", row));
  endtask

  initial begin
    int n;
    logic oe;
    logic [7:0] d;

    rst = 1'b1;
    nf.f_io_i = 8'h00; nf.f_cle_i = 1'b0; nf.f_ale_i = 1'b0;
    nf.f_wen_i = 1'b1; nf.f_ren_i = 1'b1;
    m_half = 0; m_row = 0; m_col = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: ready, not driving even with REN low.
    chk("rst_rb", 32'(nf.f_rb_o), 32'd1);
    ren_pulse(oe, d);
    chk("rst_oe", 32'(oe), 32'd0);

    // Page 5: program random data, program busy 50, read busy 20, wrap on the 513th byte.
    send_prog(5, 8'h00);
    for (int i = 0; i < PB; i++) write_byte(8'($urandom));
    cmd(8'h10);
    measure_busy(n);
    chk("t_prog", n, 50);
    send_read(0, 5, 8'h00);
    measure_busy(n);
    chk("t_r", n, 20);
    read_check(PB + 1, "p5");

    // Page 511 read from the upper half via 01h, crossing the page wrap.
    fill_page(511);
    send_read(1, 511, 8'h00);
    wait_ready("p511_ready");
    read_check(257, "p511");

    // Page 3 programmed with i[7:0] while the half pointer is still set, read back from col 0.
    send_prog(3, 8'h00);
    for (int i = 0; i < PB; i++) write_byte(8'(i));
    cmd(8'h10);
    wait_ready("p3_ready");
    send_read(0, 3, 8'h00);
    wait_ready("p3_rready");
    read_check(PB, "p3");

    // Status during and after program busy; a following 00h clears status mode.
    send_prog(7, 8'h00);
    for (int i = 0; i < 20; i++) write_byte(8'($urandom));
    cmd(8'h10);
    cmd(8'h70);
    ren_pulse(oe, d);
    chk("st_busy", {oe, d}, {1'b1, 8'h80});
    wait_ready("st_ready");
    ren_pulse(oe, d);
    chk("st_ready_val", {oe, d}, {1'b1, 8'hC0});
    cmd(8'h00);
    m_half = 0;
    ren_pulse(oe, d);
    chk("st_clr", 32'(oe), 32'd0);

    // FFh during read busy: 5 busy cycles from the FFh edge, then idle.
    send_read(0, 5, 8'h00);
    cmd(8'hFF);
    measure_busy(n);
    chk("t_rst", n, 5);
    m_half = 0;
    ren_pulse(oe, d);
    chk("ff_idle_oe", 32'(oe), 32'd0);

    // 10h outside program data aborts addressing: later address cycles are ignored.
    cmd(8'h00);
    addr(8'h00);
    cmd(8'h10);
    addr(8'h05);
    addr(8'h00);
    @(negedge clk);
    chk("c10_idle_rb", 32'(nf.f_rb_o), 32'd1);
    @(posedge clk); #1;

    // Reset during read busy releases F_RB on the next cycle.
    send_read(0, 5, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_abort_rb", 32'(nf.f_rb_o), 32'd1);

    // Reset after 100 program bytes: written bytes stay, later data cycles are dropped.
    fill_page(9);
    send_prog(9, 8'h00);
    for (int i = 0; i < 100; i++) write_byte(8'($urandom));
    #0 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_half = 0;
    chk("rst_prog_rb", 32'(nf.f_rb_o), 32'd1);
    ren_pulse(oe, d);
    chk("rst_prog_oe", 32'(oe), 32'd0);
    for (int i = 0; i < 20; i++) bus_cycle(1'b0, 1'b0, 8'($urandom));
    send_read(0, 9, 8'h00);
    wait_ready("p9_ready");
    read_check(PB, "p9");

    // REN low while WEN low: no drive; the REN rise still advances the column once.
    send_read(0, 9, 8'h10);
    wait_ready("sim_ready");
    read_check(3, "sim_pre");
    nf.f_wen_i = 1'b0;
    nf.f_ren_i = 1'b0;
    @(negedge clk);
    chk("sim_oe", 32'(nf.f_oe_o), 32'd0);
    @(posedge clk); #1;
    nf.f_ren_i = 1'b1;
    nf.f_wen_i = 1'b1;
    @(posedge clk); #1;
    m_col = (m_col + 1) % PB;
    read_check(2, "sim_post");

    // Status mode takes priority over read data.
    cmd(8'h70);
    ren_pulse(oe, d);
    chk("st_prio", {oe, d}, {1'b1, 8'hC0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
